// File: rtl/whizgraphics_line_renderer.sv
// Background-only scanline renderer: tile RAM, 32x32 tile map, LCD registers, 160-pixel line stream.
// Latency: first pix_valid 3 cycles after the drawline edge-detect cycle, then 160 contiguous pixels.
// Backpressure: none; the bus is never stalled and the pixel sink must accept one pixel per cycle.
//
// Ports: clk/reset (sync, active-high); db_* system data bus (db_rdata registered, valid the
// cycle after db_re); drawline (rising edge starts a line); renderComplete (level, frame done);
// pix_valid/pix_x/pix_y/pix_data pixel stream; dbg_ly/dbg_busy live only when DEBUG_OUT=1.
// Optional macro WHIZGFX_PALETTE_EN maps raw shades through BGP before output.
module whizgraphics_line_renderer #(
    parameter int DEBUG_OUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] db_addr,
    input  logic [7:0]  db_wdata,
    input  logic        db_we,
    input  logic        db_re,
    output logic [7:0]  db_rdata,
    input  logic        drawline,
    output logic        renderComplete,
    output logic        pix_valid,
    output logic [7:0]  pix_x,
    output logic [7:0]  pix_y,
    output logic [1:0]  pix_data,
    output logic [7:0]  dbg_ly,
    output logic        dbg_busy
);
    typedef enum logic {S_IDLE, S_RENDER} state_t;

    // Tile RAM split into low/high bitplane halves so one renderer read yields a full row.
    logic [7:0] lo_ram  [0:3071];
    logic [7:0] hi_ram  [0:3071];
    logic [7:0] map_ram [0:1023];

    logic [7:0] lcdc_q, scy_q, scx_q, bgp_q, ly_q, db_rdata_q;
    logic       drawline_q, rc_q;
    state_t     state_q, state_d;

    // Per-line context, frozen at line start
    logic [7:0] line_y_q, scx_line_q, bgy_q, x_cnt_q;

    // Pipeline: stage 1 map read, stage 2 tile read, stage 3 output
    logic       s1_vld_q, s2_vld_q, pix_valid_q;
    logic [7:0] s1_x_q, s2_x_q, pix_x_q, s1_tile_q, s2_lo_q, s2_hi_q;
    logic [2:0] s1_fine_q, s2_fine_q;
    logic [1:0] pix_data_q;

    // Bus decode
    logic        tile_hit, map_hit;
    logic [11:0] tile_idx;
    assign tile_hit = (db_addr >= 16'h8000) && (db_addr <= 16'h97FF);
    assign map_hit  = (db_addr[15:10] == 6'b100110);
    assign tile_idx = db_addr[12:1];

    logic line_start, last_pix, busy, issue;
    assign line_start = drawline && !drawline_q && (state_q == S_IDLE) && lcdc_q[7];
    assign last_pix   = pix_valid_q && (pix_x_q == 8'd159);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state. The line ends when its last pixel has left the output stage.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (line_start) state_d = S_RENDER;
            S_RENDER: if (last_pix)   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy  = (state_q == S_RENDER);
        issue = busy && (x_cnt_q < 8'd160);
    end

    // Registers, LY, renderComplete, bus read data
    always_ff @(posedge clk) begin
        if (reset) begin
            lcdc_q     <= 8'h00;
            scy_q      <= 8'h00;
            scx_q      <= 8'h00;
            bgp_q      <= 8'h00;
            ly_q       <= 8'h00;
            rc_q       <= 1'b0;
            drawline_q <= 1'b0;
            db_rdata_q <= 8'hFF;
        end else begin
            drawline_q <= drawline;
            if (db_we) begin
                case (db_addr)
                    16'hFF40: lcdc_q <= db_wdata;
                    16'hFF42: scy_q  <= db_wdata;
                    16'hFF43: scx_q  <= db_wdata;
                    16'hFF47: bgp_q  <= db_wdata;
                    default: ;
                endcase
            end
            // A bus write to LY wins over the end-of-line increment
            if (db_we && db_addr == 16'hFF44) ly_q <= 8'h00;
            else if (last_pix)                ly_q <= (ly_q == 8'd143) ? 8'h00 : ly_q + 8'd1;
            if (line_start)                         rc_q <= 1'b0;
            else if (last_pix && ly_q == 8'd143)    rc_q <= 1'b1;
            if (db_re) begin
                if (tile_hit)                  db_rdata_q <= db_addr[0] ? hi_ram[tile_idx] : lo_ram[tile_idx];
                else if (map_hit)              db_rdata_q <= map_ram[db_addr[9:0]];
                else if (db_addr == 16'hFF40)  db_rdata_q <= lcdc_q;
                else if (db_addr == 16'hFF42)  db_rdata_q <= scy_q;
                else if (db_addr == 16'hFF43)  db_rdata_q <= scx_q;
                else if (db_addr == 16'hFF44)  db_rdata_q <= ly_q;
                else if (db_addr == 16'hFF47)  db_rdata_q <= bgp_q;
                else                           db_rdata_q <= 8'hFF;
            end
        end
    end

    // Memories keep their contents across reset
    always_ff @(posedge clk) begin
        if (db_we && tile_hit) begin
            if (db_addr[0]) hi_ram[tile_idx] <= db_wdata;
            else            lo_ram[tile_idx] <= db_wdata;
        end
        if (db_we && map_hit) map_ram[db_addr[9:0]] <= db_wdata;
    end

    // Line context and pipeline valids
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt_q     <= 8'd0;
            line_y_q    <= 8'd0;
            scx_line_q  <= 8'd0;
            bgy_q       <= 8'd0;
            s1_vld_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            pix_valid_q <= 1'b0;
        end else begin
            if (line_start) begin
                x_cnt_q    <= 8'd0;
                line_y_q   <= ly_q;
                scx_line_q <= scx_q;
                bgy_q      <= ly_q + scy_q;
            end else if (issue) begin
                x_cnt_q <= x_cnt_q + 8'd1;
            end
            s1_vld_q    <= issue;
            s2_vld_q    <= s1_vld_q;
            pix_valid_q <= s2_vld_q;
        end
    end

    logic [7:0]  bgx;
    logic [9:0]  map_rd_idx;
    logic [11:0] tile_rd_idx;
    logic [2:0]  bit_sel;
    logic [1:0]  shade, shade_out;
    assign bgx         = x_cnt_q + scx_line_q;
    assign map_rd_idx  = {bgy_q[7:3], bgx[7:3]};
    assign tile_rd_idx = {1'b0, s1_tile_q, bgy_q[2:0]};
    assign bit_sel     = 3'd7 - s2_fine_q;
    assign shade       = {s2_hi_q[bit_sel], s2_lo_q[bit_sel]};

`ifdef WHIZGFX_PALETTE_EN
    always_comb begin
        case (shade)
            2'd0:    shade_out = bgp_q[1:0];
            2'd1:    shade_out = bgp_q[3:2];
            2'd2:    shade_out = bgp_q[5:4];
            default: shade_out = bgp_q[7:6];
        endcase
    end
`else
    assign shade_out = shade;
`endif

    // Pipeline data path; synchronous reads return old data on a same-cycle bus write
    always_ff @(posedge clk) begin
        s1_tile_q  <= map_ram[map_rd_idx];
        s1_x_q     <= x_cnt_q;
        s1_fine_q  <= bgx[2:0];
        s2_lo_q    <= lo_ram[tile_rd_idx];
        s2_hi_q    <= hi_ram[tile_rd_idx];
        s2_x_q     <= s1_x_q;
        s2_fine_q  <= s1_fine_q;
        pix_x_q    <= s2_x_q;
        pix_data_q <= shade_out;
    end

    // pix_valid is gated so it drops in the very cycle reset is sampled
    assign pix_valid      = pix_valid_q && !reset;
    assign pix_x          = pix_x_q;
    assign pix_y          = line_y_q;
    assign pix_data       = pix_data_q;
    assign renderComplete = rc_q;
    assign db_rdata       = db_rdata_q;

    generate
        if (DEBUG_OUT != 0) begin : g_dbg
            assign dbg_ly   = ly_q;
            assign dbg_busy = busy;
        end else begin : g_nodbg
            assign dbg_ly   = 8'h00;
            assign dbg_busy = 1'b0;
        end
    endgenerate
endmodule

// File: tb/tb_whizgraphics_line_renderer.sv
module tb_whizgraphics_line_renderer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] db_addr = 16'h0;
    logic [7:0]  db_wdata = 8'h0;
    logic        db_we = 1'b0, db_re = 1'b0, drawline = 1'b0;
    logic [7:0]  db_rdata, pix_x, pix_y, dbg_ly;
    logic        renderComplete, pix_valid, dbg_busy;
    logic [1:0]  pix_data;

    whizgraphics_line_renderer #(.DEBUG_OUT(1)) dut (
        .clk(clk), .reset(reset), .db_addr(db_addr), .db_wdata(db_wdata),
        .db_we(db_we), .db_re(db_re), .db_rdata(db_rdata), .drawline(drawline),
        .renderComplete(renderComplete), .pix_valid(pix_valid), .pix_x(pix_x),
        .pix_y(pix_y), .pix_data(pix_data), .dbg_ly(dbg_ly), .dbg_busy(dbg_busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int tmem [4096];
    int mmem [1024];
    int m_scx = 0, m_scy = 0, m_bgp = 0, m_ly = 0;
    int pix_cap [160];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input int addr, input int data);
        db_addr  = addr[15:0];
        db_wdata = data[7:0];
        db_we    = 1'b1;
        tick();
        db_we    = 1'b0;
        if (addr >= 16'h8000 && addr < 16'h9000) tmem[addr - 16'h8000] = data & 255;
        if (addr >= 16'h9800 && addr < 16'h9C00) mmem[addr - 16'h9800] = data & 255;
        if (addr == 16'hFF42) m_scy = data & 255;
        if (addr == 16'hFF43) m_scx = data & 255;
        if (addr == 16'hFF47) m_bgp = data & 255;
        if (addr == 16'hFF44) m_ly  = 0;
    endtask

    task automatic bus_rd(input int addr, output logic [7:0] data);
        db_addr = addr[15:0];
        db_re   = 1'b1;
        tick();
        db_re   = 1'b0;
        data    = db_rdata;
    endtask

    // Expected output straight from the addressing rules
    function automatic int exp_pix(input int x, input int ly);
        int bgx, bgy, t, lo, hi, b, s;
        bgx = (x + m_scx) % 256;
        bgy = (ly + m_scy) % 256;
        t   = mmem[(bgy / 8) * 32 + bgx / 8];
        lo  = tmem[t * 16 + (bgy % 8) * 2];
        hi  = tmem[t * 16 + (bgy % 8) * 2 + 1];
        b   = 7 - (bgx % 8);
        s   = ((hi >> b) & 1) * 2 + ((lo >> b) & 1);
`ifdef WHIZGFX_PALETTE_EN
        return (m_bgp >> (2 * s)) & 3;
`else
        return s;
`endif
    endfunction

    // Pulse drawline, collect one line and compare against the model.
    // kill_lcdc clears LCDC from the bus partway through the line.
    task automatic render_line(input bit kill_lcdc);
        int  lat = -1, cnt = 0, errs = 0, yerr = 0, cyc = 0, ly0;
        bit  seen = 0, done = 0;
        logic rc_last = 1'b0;
        ly0 = m_ly;
        drawline = 1'b1;
        tick();
        drawline = 1'b0;
        check("rc_clear_on_edge", renderComplete, 0);
        while (!done && cyc < 400) begin
            if (kill_lcdc && cyc == 20) begin
                db_addr = 16'hFF40; db_wdata = 8'h00; db_we = 1'b1;
            end
            tick();
            db_we = 1'b0;
            cyc++;
            if (pix_valid) begin
                if (!seen) lat = cyc;
                seen = 1;
                if (cnt < 160) pix_cap[cnt] = int'(pix_data);
                if (pix_x !== cnt[7:0]) errs++;
                if (pix_y !== ly0[7:0]) yerr++;
                if (cnt >= 160 || int'(pix_data) != exp_pix(cnt, ly0)) errs++;
                rc_last = renderComplete;
                cnt++;
            end else if (seen) begin
                done = 1;
            end
        end
        m_ly = (ly0 == 143) ? 0 : ly0 + 1;
        check("line_done", done, 1);
        check("first_latency", lat, 3);
        check("pixel_count", cnt, 160);
        check("pixel_errs", errs, 0);
        check("pix_y_errs", yerr, 0);
        check("rc_during_last_pix", rc_last, 0);
        check("rc_after_line", renderComplete, (ly0 == 143) ? 1 : 0);
        check("ly_after_line", dbg_ly, m_ly);
    endtask

    logic [7:0] rd;
    int         vcnt;

    initial begin
        // Reset
        repeat (3) tick();
        check("reset_pix_valid", pix_valid, 0);
        check("reset_rc", renderComplete, 0);
        check("reset_rdata", db_rdata, 8'hFF);
        check("reset_dbg_ly", dbg_ly, 0);
        check("reset_dbg_busy", dbg_busy, 0);
        reset = 1'b0;
        tick();
        bus_rd(16'hFF44, rd); check("reset_ly", rd, 8'h00);
        bus_rd(16'hFF40, rd); check("reset_lcdc", rd, 8'h00);

        // Random tile contents, then bus readback and unmapped read
        for (int i = 0; i < 4096; i++) bus_wr(16'h8000 + i, $urandom_range(0, 255));
        bus_wr(16'h8002, 8'h55);
        bus_wr(16'h8003, 8'h33);
        bus_rd(16'h8002, rd); check("rd_8002", rd, 8'h55);
        bus_rd(16'h8003, rd); check("rd_8003", rd, 8'h33);
        bus_rd(16'hA000, rd); check("rd_unmapped", rd, 8'hFF);
        bus_wr(16'hFF47, 8'hE4);
        bus_rd(16'hFF47, rd); check("rd_bgp", rd, 8'hE4);

        // Line 0 with known tile 0 row 0 and an all-zero map
        for (int i = 0; i < 1024; i++) bus_wr(16'h9800 + i, 0);
        bus_wr(16'h8000, 8'h0F);
        bus_wr(16'h8001, 8'h33);
        bus_wr(16'hFF40, 8'h80);
        bus_wr(16'hFF42, 0);
        bus_wr(16'hFF43, 0);
        render_line(0);
        begin
            int exp8 [8] = '{0, 0, 2, 2, 1, 1, 3, 3};
            for (int i = 0; i < 8; i++) check($sformatf("line0_x%0d", i), pix_cap[i], exp8[i]);
        end
        bus_rd(16'hFF44, rd); check("ly_is_1", rd, 8'h01);

        // Scroll X
        bus_wr(16'hFF44, 0);
        bus_wr(16'hFF43, 3);
        render_line(0);
        check("scx3_x0", pix_cap[0], 2);
        bus_wr(16'hFF44, 0);
        bus_wr(16'hFF43, 8'hFE);
        render_line(0);
        check("scxFE_x0", pix_cap[0], 3);

        // Edge ignored with LCD disabled
        bus_wr(16'hFF40, 8'h00);
        drawline = 1'b1; tick(); drawline = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (pix_valid) vcnt++; end
        check("disabled_no_pix", vcnt, 0);
        check("disabled_ly", dbg_ly, m_ly);
        check("disabled_idle", dbg_busy, 0);
        bus_wr(16'hFF40, 8'h80);

        // Full frame over random map, random scroll per line
        for (int i = 0; i < 1024; i++) bus_wr(16'h9800 + i, $urandom_range(0, 255));
        bus_wr(16'hFF44, 0);
        for (int l = 0; l < 144; l++) begin
            bus_wr(16'hFF43, $urandom_range(0, 255));
            bus_wr(16'hFF42, $urandom_range(0, 255));
            if (l % 16 == 0) bus_wr(16'hFF47, $urandom_range(0, 255));
            check("rc_before_frame_end", renderComplete, (l == 0) ? renderComplete : 1'b0);
            render_line(0);
        end
        check("frame_rc", renderComplete, 1);
        bus_rd(16'hFF44, rd); check("frame_ly", rd, 8'h00);
        check("rc_held", renderComplete, 1);
        render_line(0);
        check("rc_cleared", renderComplete, 0);

        // Palette: shade 3 through BGP=0x1B
        bus_wr(16'hFF44, 0);
        bus_wr(16'hFF43, 0);
        bus_wr(16'hFF42, 0);
        bus_wr(16'hFF47, 8'h1B);
        bus_wr(16'h9800, 1);
        bus_wr(16'h8010, 8'hFF);
        bus_wr(16'h8011, 8'hFF);
        render_line(0);
`ifdef WHIZGFX_PALETTE_EN
        check("bgp1B_shade3", pix_cap[0], 0);
`else
        check("bgp1B_shade3", pix_cap[0], 3);
`endif

        // LCDC cleared mid-line: the line still completes, next edge ignored
        bus_wr(16'hFF43, $urandom_range(0, 255));
        render_line(1);
        bus_rd(16'hFF40, rd); check("lcdc_cleared", rd, 8'h00);
        drawline = 1'b1; tick(); drawline = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (pix_valid) vcnt++; end
        check("after_kill_no_pix", vcnt, 0);

        // Reset mid-line
        bus_wr(16'hFF40, 8'h80);
        drawline = 1'b1; tick(); drawline = 1'b0;
        vcnt = 0;
        while (!pix_valid && vcnt < 20) begin tick(); vcnt++; end
        check("pix_before_reset", pix_valid, 1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("pix_drop_on_reset", pix_valid, 0);
        tick();
        check("reset_busy", dbg_busy, 0);
        tick();
        reset = 1'b0;
        tick();
        check("post_reset_pix", pix_valid, 0);
        check("post_reset_ly", dbg_ly, 0);
        check("post_reset_rc", renderComplete, 0);
        bus_rd(16'hFF40, rd); check("post_reset_lcdc", rd, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
